// File: rtl/fsm_umbrales_n_pkg.sv
// Shared definitions for the FIFO watermark monitor: state encodings,
// count-width derivation and the error_id code reserved for bad thresholds.
package fsm_umbrales_n_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    localparam logic [2:0] ERR_ID_CFG  = 3'd7;
    localparam int         N_FIFOS_MAX = 8;

    // One extra bit so a completely full FIFO (2^ADDR_WIDTH) is representable.
    function automatic int cnt_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/fsm_umbrales_n_umbral_canal.sv
// Per-FIFO watermark comparators and pause hysteresis flop.
// clr_i forces all flags low; with neither clr_i nor eval_i the flags hold.
module umbral_canal #(
    parameter int CNT_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             eval_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic [CNT_W-1:0] alto_i,
    input  logic [CNT_W-1:0] bajo_i,
    output logic             almost_full_o,
    output logic             almost_empty_o,
    output logic             pause_o
);

    logic hit_alto, hit_bajo;
    logic af_q, af_d;
    logic ae_q, ae_d;
    logic pause_q, pause_d;

    assign hit_alto = (count_i >= alto_i);
    assign hit_bajo = (count_i <= bajo_i);

    always_comb begin
        af_d    = af_q;
        ae_d    = ae_q;
        pause_d = pause_q;
        if (clr_i) begin
            af_d    = 1'b0;
            ae_d    = 1'b0;
            pause_d = 1'b0;
        end else if (eval_i) begin
            af_d = hit_alto;
            ae_d = hit_bajo;
            // Between the watermarks pause keeps its previous value.
            if (hit_alto) begin
                pause_d = 1'b1;
            end else if (hit_bajo) begin
                pause_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            af_q    <= 1'b0;
            ae_q    <= 1'b0;
            pause_q <= 1'b0;
        end else begin
            af_q    <= af_d;
            ae_q    <= ae_d;
            pause_q <= pause_d;
        end
    end

    assign almost_full_o  = af_q;
    assign almost_empty_o = ae_q;
    assign pause_o        = pause_q;

endmodule

// File: rtl/fsm_umbrales_n.sv
// Threshold supervisor for N FIFOs: configures watermarks, tracks activity,
// and latches the first error (FIFO or configuration) until reset.
module fsm_umbrales_n
    import fsm_umbrales_n_pkg::*;
#(
    parameter  int N_FIFOS    = 4,
    parameter  int ADDR_WIDTH = 2,
    localparam int CNT_W      = cnt_width(ADDR_WIDTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     init,
    input  logic [CNT_W-1:0]         umbral_alto,
    input  logic [CNT_W-1:0]         umbral_bajo,
    input  logic [N_FIFOS*CNT_W-1:0] fifo_count,
    input  logic [N_FIFOS-1:0]       fifo_error,
    output logic [N_FIFOS-1:0]       almost_full,
    output logic [N_FIFOS-1:0]       almost_empty,
    output logic [N_FIFOS-1:0]       pause,
    output logic [2:0]               state,
    output logic                     idle_out,
    output logic                     active_out,
    output logic                     error_out,
    output logic                     cfg_error,
    output logic [2:0]               error_id
);

    state_e           state_q;
    logic [CNT_W-1:0] alto_q, bajo_q;
    logic             cfg_error_q;
    logic [2:0]       error_id_q;
    logic [2:0]       err_idx;
    logic             any_err, any_cnt;
    logic             eval_en, clr_en;

    assign any_err = |fifo_error;
    assign any_cnt = |fifo_count;

    // Lowest-index failing FIFO wins: scan downward so the last hit is the smallest.
    always_comb begin
        err_idx = '0;
        for (int i = N_FIFOS - 1; i >= 0; i--) begin
            if (fifo_error[i]) begin
                err_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RESET;
            alto_q      <= '0;
            bajo_q      <= '0;
            cfg_error_q <= 1'b0;
            error_id_q  <= '0;
        end else begin
            case (state_q)
                ST_RESET: state_q <= ST_INIT;
                ST_INIT: begin
                    alto_q <= umbral_alto;
                    bajo_q <= umbral_bajo;
                    if (any_err) begin
                        state_q    <= ST_ERROR;
                        error_id_q <= err_idx;
                    end else if (!init) begin
                        // Validate the pair being captured on this same edge.
                        if (umbral_bajo >= umbral_alto) begin
                            state_q     <= ST_ERROR;
                            cfg_error_q <= 1'b1;
                            error_id_q  <= ERR_ID_CFG;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_IDLE, ST_ACTIVE: begin
                    if (any_err) begin
                        state_q    <= ST_ERROR;
                        error_id_q <= err_idx;
                    end else if (init) begin
                        state_q <= ST_INIT;
                    end else if (any_cnt) begin
                        state_q <= ST_ACTIVE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ERROR: state_q <= ST_ERROR;
                default:  state_q <= ST_RESET;
            endcase
        end
    end

    // Channels evaluate in IDLE/ACTIVE, freeze in ERROR, and are cleared otherwise.
    assign eval_en = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
    assign clr_en  = !eval_en && (state_q != ST_ERROR);

    for (genvar g = 0; g < N_FIFOS; g++) begin : g_canal
        umbral_canal #(
            .CNT_W(CNT_W)
        ) u_canal (
            .clk_i         (clk),
            .rst_ni        (reset),
            .eval_i        (eval_en),
            .clr_i         (clr_en),
            .count_i       (fifo_count[g*CNT_W +: CNT_W]),
            .alto_i        (alto_q),
            .bajo_i        (bajo_q),
            .almost_full_o (almost_full[g]),
            .almost_empty_o(almost_empty[g]),
            .pause_o       (pause[g])
        );
    end

    assign state      = state_q;
    assign idle_out   = (state_q == ST_IDLE);
    assign active_out = (state_q == ST_ACTIVE);
    assign error_out  = (state_q == ST_ERROR);
    assign cfg_error  = cfg_error_q;
    assign error_id   = error_id_q;

endmodule

// File: tb/tb_fsm_umbrales_n.sv
// Scoreboard bench for fsm_umbrales_n: default 4x2 instance plus an 8x3 instance.
module tb_fsm_umbrales_n;

    localparam int S_STATE = 0, S_FLAGS = 1, S_PAUSE = 2, S_AF = 3, S_AE = 4,
                   S_CFG = 5, S_EID = 6, S8_STATE = 7, S8_PAUSE = 8, S8_AF = 9;

    logic        clk = 1'b0;
    logic        reset, init, reset8, init8;
    logic [2:0]  alto, bajo;
    logic [3:0]  alto8, bajo8;
    logic [11:0] cnt;
    logic [31:0] cnt8;
    logic [3:0]  ferr;
    logic [7:0]  ferr8;
    logic [3:0]  af, ae, pz;
    logic [7:0]  af8, ae8, pz8;
    logic [2:0]  st, eid, st8, eid8;
    logic        idle_o, act_o, err_o, cfg_o;
    logic        idle8, act8, err8, cfg8;

    always #5 clk = ~clk;

    fsm_umbrales_n u_dut (
        .clk(clk), .reset(reset), .init(init), .umbral_alto(alto), .umbral_bajo(bajo),
        .fifo_count(cnt), .fifo_error(ferr), .almost_full(af), .almost_empty(ae),
        .pause(pz), .state(st), .idle_out(idle_o), .active_out(act_o),
        .error_out(err_o), .cfg_error(cfg_o), .error_id(eid)
    );

    fsm_umbrales_n #(.N_FIFOS(8), .ADDR_WIDTH(3)) u_dut8 (
        .clk(clk), .reset(reset8), .init(init8), .umbral_alto(alto8), .umbral_bajo(bajo8),
        .fifo_count(cnt8), .fifo_error(ferr8), .almost_full(af8), .almost_empty(ae8),
        .pause(pz8), .state(st8), .idle_out(idle8), .active_out(act8),
        .error_out(err8), .cfg_error(cfg8), .error_id(eid8)
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            S_STATE:  return 32'(st);
            S_FLAGS:  return 32'({idle_o, act_o, err_o});
            S_PAUSE:  return 32'(pz);
            S_AF:     return 32'(af);
            S_AE:     return 32'(ae);
            S_CFG:    return 32'(cfg_o);
            S_EID:    return 32'(eid);
            S8_STATE: return 32'(st8);
            S8_PAUSE: return 32'(pz8);
            S8_AF:    return 32'(af8);
            default:  return '1;
        endcase
    endfunction

    task automatic ex(input string tag, input int sel, input logic [31:0] v, input int dly);
        exp_t e;
        e.tag = tag; e.sel = sel; e.val = v; e.due = cyc + dly;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk(e.tag, obs(e.sel), e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        drain();
    endtask

    task automatic all_zero_now(input string tag);
        ex({tag, "_state"}, S_STATE, 0, 0);
        ex({tag, "_flags"}, S_FLAGS, 0, 0);
        ex({tag, "_pause"}, S_PAUSE, 0, 0);
        ex({tag, "_af"},    S_AF,    0, 0);
        ex({tag, "_ae"},    S_AE,    0, 0);
        ex({tag, "_cfg"},   S_CFG,   0, 0);
        ex({tag, "_eid"},   S_EID,   0, 0);
        drain();
    endtask

    // Async reset pulse placed between clock edges; outputs must clear before the next edge.
    task automatic reset_pulse(input string tag);
        reset = 1'b0;
        #2;
        all_zero_now(tag);
        reset = 1'b1;
        #1;
    endtask

    initial begin
        reset = 0; init = 1; alto = 3'd3; bajo = 3'd1; cnt = '0; ferr = '0;
        reset8 = 0; init8 = 1; alto8 = 4'd8; bajo8 = 4'd1; cnt8 = '0; ferr8 = '0;
        #12;
        all_zero_now("rst");
        reset = 1'b1;
        ex("rel_state", S_STATE, 0, 0); drain();

        // Three INIT cycles then IDLE
        ex("init1", S_STATE, 1, 1); ex("init1_flags", S_FLAGS, 0, 1); tick();
        ex("init2", S_STATE, 1, 1); tick();
        ex("init3", S_STATE, 1, 1); tick();
        init = 0;
        ex("idle", S_STATE, 2, 1); ex("idle_flags", S_FLAGS, 3'b100, 1);
        ex("idle_ae_held0", S_AE, 0, 1); tick();
        ex("idle_ae", S_AE, 4'hF, 1); ex("idle_af", S_AF, 0, 1); tick();

        // IDLE <-> ACTIVE on occupancy
        cnt[0 +: 3] = 3'd1;
        ex("active", S_STATE, 3, 1); ex("active_flags", S_FLAGS, 3'b010, 1);
        ex("ae_eq_bajo", S_AE, 4'hF, 1); tick();
        cnt[0 +: 3] = 3'd0;
        ex("back_idle", S_STATE, 2, 1); tick();

        // Hysteresis on FIFO2: counts 0,3,2,1,2,4
        cnt[6 +: 3] = 3'd0; ex("hy0", S_PAUSE, 4'b0000, 1); tick();
        cnt[6 +: 3] = 3'd3; ex("hy3", S_PAUSE, 4'b0100, 1); ex("hy3_af", S_AF, 4'b0100, 1); tick();
        cnt[6 +: 3] = 3'd2; ex("hy2", S_PAUSE, 4'b0100, 1); ex("hy2_ae", S_AE, 4'b1011, 1);
        ex("hy2_state", S_STATE, 3, 1); tick();
        cnt[6 +: 3] = 3'd1; ex("hy1", S_PAUSE, 4'b0000, 1); ex("hy1_ae", S_AE, 4'hF, 1); tick();
        cnt[6 +: 3] = 3'd2; ex("hy2b", S_PAUSE, 4'b0000, 1); tick();
        cnt[6 +: 3] = 3'd4; ex("hy_full", S_PAUSE, 4'b0100, 1); ex("full_af", S_AF, 4'b0100, 1); tick();

        // Async reset while ACTIVE, then reconfigure
        reset_pulse("midrst");
        ex("midrst_hold", S_STATE, 0, 0); drain();
        init = 1;
        ex("re_init", S_STATE, 1, 1); ex("re_init_pz", S_PAUSE, 0, 1); tick();
        init = 0;
        ex("re_idle", S_STATE, 2, 1); tick();
        cnt[3 +: 3] = 3'd2;
        ex("re_active", S_STATE, 3, 1); tick();

        // FIFO error 1010 -> ERROR with id 1, then frozen
        ferr = 4'b1010;
        ex("err_state", S_STATE, 4, 1); ex("err_flags", S_FLAGS, 3'b001, 1);
        ex("err_id", S_EID, 1, 1); ex("err_cfg", S_CFG, 0, 1);
        ex("err_pz", S_PAUSE, 4'b0100, 1); ex("err_ae", S_AE, 4'b1001, 1); tick();
        ferr = '0; init = 1; cnt = '0;
        ex("stky_state", S_STATE, 4, 1); tick();
        ex("stky_state2", S_STATE, 4, 1); ex("frz_pz", S_PAUSE, 4'b0100, 1);
        ex("frz_ae", S_AE, 4'b1001, 1); ex("frz_af", S_AF, 4'b0100, 1); ex("stky_id", S_EID, 1, 1); tick();

        // Invalid thresholds alto == bajo
        alto = 3'd2; bajo = 3'd2; init = 1;
        reset_pulse("rst2");
        ex("cfg_init", S_STATE, 1, 1); tick();
        init = 0;
        ex("cfg_state", S_STATE, 4, 1); ex("cfg_flag", S_CFG, 1, 1); ex("cfg_id", S_EID, 7, 1);
        ex("cfg_flags", S_FLAGS, 3'b001, 1); ex("cfg_pz", S_PAUSE, 0, 1); tick();
        ex("cfg_sticky", S_CFG, 1, 1); tick();

        // Just-valid pair bajo = alto-1, full count hits almost_full
        alto = 3'd4; bajo = 3'd3; init = 0;
        reset_pulse("rst3");
        ex("ok_init", S_STATE, 1, 1); tick();
        ex("ok_idle", S_STATE, 2, 1); ex("ok_cfg", S_CFG, 0, 1); tick();
        cnt[0 +: 3] = 3'd4;
        ex("ok_af", S_AF, 4'b0001, 1); ex("ok_pz", S_PAUSE, 4'b0001, 1); tick();
        cnt = '0;

        // FIFO error during INIT, lowest index of 1100 is 2
        init = 1; alto = 3'd3; bajo = 3'd1;
        reset_pulse("rst4");
        ferr = 4'b1100;
        ex("ie_init", S_STATE, 1, 1); tick();
        ex("ie_state", S_STATE, 4, 1); ex("ie_id", S_EID, 2, 1); ex("ie_cfg", S_CFG, 0, 1); tick();
        ferr = '0;

        // Wide instance: FIFO7 hysteresis with alto=8 (full), bajo=1
        #2;
        reset8 = 1'b1;
        ex("w_init", S8_STATE, 1, 1); tick();
        init8 = 0;
        ex("w_idle", S8_STATE, 2, 1); tick();
        cnt8[28 +: 4] = 4'd0; ex("w0", S8_PAUSE, 8'h00, 1); tick();
        cnt8[28 +: 4] = 4'd8; ex("w8", S8_PAUSE, 8'h80, 1); ex("w8_af", S8_AF, 8'h80, 1); tick();
        cnt8[28 +: 4] = 4'd2; ex("w2", S8_PAUSE, 8'h80, 1); tick();
        cnt8[28 +: 4] = 4'd1; ex("w1", S8_PAUSE, 8'h00, 1); tick();
        cnt8[28 +: 4] = 4'd2; ex("w2b", S8_PAUSE, 8'h00, 1); ex("w_active", S8_STATE, 3, 1); tick();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fsm_umbrales_n.md
FSM_UMBRALES_N -- requirements
Module: fsm_umbrales_n

Interface
REQ-001 Parameter N_FIFOS, default 4: number of monitored FIFOs (1..8).
REQ-002 Parameter ADDR_WIDTH, default 2: FIFO address width; count width CNT_W = ADDR_WIDTH+1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 init  input  1  request threshold (re)configuration.
REQ-006 umbral_alto  input  CNT_W  high watermark.
REQ-007 umbral_bajo  input  CNT_W  low watermark.
REQ-008 fifo_count  input  N_FIFOS*CNT_W  packed per-FIFO occupancy; FIFO i at bits [i*CNT_W +: CNT_W].
REQ-009 fifo_error  input  N_FIFOS  per-FIFO overflow/underflow flag.
REQ-010 almost_full  output  N_FIFOS  registered, bit i = count_i >= latched alto.
REQ-011 almost_empty  output  N_FIFOS  registered, bit i = count_i <= latched bajo.
REQ-012 pause  output  N_FIFOS  registered per-FIFO backpressure with hysteresis.
REQ-013 state  output  3  current FSM state.
REQ-014 idle_out, active_out, error_out  output  1 each  one-hot decode of state.
REQ-015 cfg_error  output  1  sticky: invalid thresholds detected.
REQ-016 error_id  output  3  index of FIFO that caused ERROR.

Function
REQ-017 States: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4; other encodings go to RESET next cycle.
REQ-018 RESET -> INIT on first rising edge with reset high.
REQ-019 INIT: umbral_alto/umbral_bajo captured into internal registers every cycle; stay while init=1.
REQ-020 INIT with init=0: if captured bajo >= alto -> ERROR and cfg_error=1, else -> IDLE.
REQ-021 IDLE -> ACTIVE when any fifo_count nonzero; ACTIVE -> IDLE when all fifo_count zero.
REQ-022 IDLE or ACTIVE with init=1 -> INIT; thresholds not re-captured outside INIT.
REQ-023 Any fifo_error bit high in INIT, IDLE or ACTIVE -> ERROR next edge; priority ERROR > INIT > occupancy.
REQ-024 On entry to ERROR, error_id latches the lowest index i with fifo_error[i]=1; cfg-caused ERROR sets error_id=7.
REQ-025 ERROR sticky; exited only by reset.
REQ-026 idle_out/active_out/error_out derived from state register only (Moore); exactly one high in IDLE/ACTIVE/ERROR, all low in RESET/INIT.
REQ-027 pause[i] set when count_i >= alto, cleared when count_i <= bajo, else held; one-cycle latency from fifo_count.
REQ-028 almost_full/almost_empty/pause evaluated only in IDLE/ACTIVE; held at 0 in RESET/INIT; frozen at last values in ERROR.
REQ-029 Comparisons unsigned, CNT_W wide; count = 2^ADDR_WIDTH (full) is valid.
REQ-030 alto = 0: almost_full constantly 1 in IDLE/ACTIVE; bajo = max: almost_empty constantly 1 (only reachable if alto invalid -> cfg_error).

Reset
REQ-031 reset low, asynchronously: state=RESET, thresholds=0, almost_full=almost_empty=pause=0, idle/active/error_out=0, cfg_error=0, error_id=0.
REQ-032 reset asserted mid-operation (any state) takes effect immediately, without waiting for clk.

Structure
REQ-033 Shared package holds state encodings, CNT_W derivation, and error_id constant 7 for configuration error.
REQ-034 One sub-module umbral_canal: per-FIFO watermark compare and pause hysteresis register, instantiated N_FIFOS times via generate.

Verification
REQ-035 Reset release, init=1 three cycles with alto=3/bajo=1, then init=0 -> states RESET,INIT,INIT,INIT,IDLE; idle_out=1.
REQ-036 In IDLE, fifo_count[0] 0->1 -> next edge ACTIVE, active_out=1; all counts back to 0 -> IDLE.
REQ-037 Hysteresis, alto=3 bajo=1, FIFO2 count 0,3,2,1,2 -> pause[2] 0,1,1,0,0 each one cycle later.
REQ-038 fifo_error=4'b1010 in ACTIVE -> ERROR, error_out=1, error_id=1; further init/count changes ignored until reset.
REQ-039 INIT with alto=2 bajo=2, init=0 -> ERROR, cfg_error=1, error_id=7.
REQ-040 reset pulsed low between edges while ACTIVE -> all outputs 0 before next edge; N_FIFOS=8, ADDR_WIDTH=3 rerun of REQ-037 on FIFO7 with alto=8.
